// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI link definitions: frame control codes, command opcodes and the
// master FSM state encoding, common to master, slave and bench.
package spi_pkg;

    localparam int CTRL_WIDTH = 3;

    localparam logic [CTRL_WIDTH-1:0] CTRL_WR_ADDR = 3'b000;
    localparam logic [CTRL_WIDTH-1:0] CTRL_WR_DATA = 3'b001;
    localparam logic [CTRL_WIDTH-1:0] CTRL_RD_ADDR = 3'b110;
    localparam logic [CTRL_WIDTH-1:0] CTRL_RD_DATA = 3'b111;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_RECV  = 3'd4,
        ST_HOLD  = 3'd5
    } spi_state_e;

    function automatic logic [CTRL_WIDTH-1:0] op_to_ctrl(input spi_op_e op);
        logic [CTRL_WIDTH-1:0] ctrl;
        case (op)
            OP_WR_ADDR: ctrl = CTRL_WR_ADDR;
            OP_WR_DATA: ctrl = CTRL_WR_DATA;
            OP_RD_ADDR: ctrl = CTRL_RD_ADDR;
            default:    ctrl = CTRL_RD_DATA;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bundle of the SPI master controller.
interface spi_master_ctrl_if #(
    parameter int FRAME_WIDTH = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [FRAME_WIDTH-1:0] cmd_data;
    logic                   rsp_valid;
    logic [FRAME_WIDTH-1:0] rsp_data;
    logic                   busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl_frame_shifter.sv
// Frame datapath: parallel-in/serial-out for the outgoing frame and
// serial-in capture of the reply byte. Sequencing comes from the master FSM.
module spi_frame_shifter
    import spi_pkg::*;
#(
    parameter int FRAME_WIDTH = 8,
    localparam int FRAME_BITS = CTRL_WIDTH + FRAME_WIDTH
) (
    input  logic                   clk,
    input  logic                   i_load,
    input  logic [FRAME_BITS-1:0]  i_frame,
    input  logic                   i_shift,
    input  logic                   i_capture,
    input  logic                   i_miso,
    output logic                   o_msb,
    output logic [FRAME_WIDTH-1:0] o_rx_next
);
    logic [FRAME_BITS-1:0]  r_piso;
    logic [FRAME_WIDTH-1:0] r_sipo;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_piso <= i_frame;
        end else if (i_shift) begin
            r_piso <= {r_piso[FRAME_BITS-2:0], 1'b0};
        end
    end

    // A capture sequence always rewrites every bit, so no clear is needed.
    always_ff @(posedge clk) begin
        if (i_capture) begin
            r_sipo <= o_rx_next;
        end
    end

    assign o_msb     = r_piso[FRAME_BITS-1];
    assign o_rx_next = {r_sipo[FRAME_WIDTH-2:0], i_miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns host commands into {ctrl, payload} MOSI frames clocked
// one bit per clk, and captures the MISO reply byte for read-data commands.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_WIDTH = 8,
    parameter int RD_GAP      = 2,
    parameter int IDLE_GAP    = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.slave    bus,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO
);
    localparam int FRAME_BITS = CTRL_WIDTH + FRAME_WIDTH;
    localparam int CNT_MAX_A  = (FRAME_BITS > RD_GAP) ? FRAME_BITS : RD_GAP;
    localparam int CNT_MAX    = (CNT_MAX_A > IDLE_GAP) ? CNT_MAX_A : IDLE_GAP;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(RD_GAP - 1);
    localparam logic [CNT_W-1:0] RECV_INIT  = CNT_W'(FRAME_WIDTH - 2);
    localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'((IDLE_GAP > 1) ? IDLE_GAP - 2 : 0);

    spi_state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_ss_n, w_ss_n_nxt;
    logic                   r_mosi, w_mosi_nxt;
    logic                   r_cmd_ready, w_cmd_ready_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic [FRAME_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
    logic                   r_is_read, w_is_read_nxt;

    logic                   w_accept;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_capture;
    logic                   w_finish;
    logic                   w_msb;
    logic [FRAME_WIDTH-1:0] w_rx_next;
    logic [FRAME_BITS-1:0]  w_frame;

    assign w_accept = bus.cmd_valid & r_cmd_ready;
    assign w_frame  = {op_to_ctrl(spi_op_e'(bus.cmd_op)), bus.cmd_data};

    spi_frame_shifter #(
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .i_load    (w_load),
        .i_frame   (w_frame),
        .i_shift   (w_shift),
        .i_capture (w_capture),
        .i_miso    (MISO),
        .o_msb     (w_msb),
        .o_rx_next (w_rx_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_is_read   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ss_n      <= w_ss_n_nxt;
            r_mosi      <= w_mosi_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_is_read   <= w_is_read_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ss_n_nxt      = r_ss_n;
        w_mosi_nxt      = r_mosi;
        w_cmd_ready_nxt = r_cmd_ready;
        w_busy_nxt      = r_busy;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_is_read_nxt   = r_is_read;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_capture       = 1'b0;
        w_finish        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load          = 1'b1;
                    w_is_read_nxt   = (bus.cmd_op == OP_RD_DATA);
                    w_ss_n_nxt      = 1'b0;
                    w_cmd_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_mosi_nxt  = w_msb;
                w_shift     = 1'b1;
                w_cnt_nxt   = SHIFT_INIT;
                w_state_nxt = ST_SHIFT;
            end
            // r_cnt counts the frame bits still to be driven after the current one.
            ST_SHIFT: begin
                if (r_cnt != '0) begin
                    w_mosi_nxt = w_msb;
                    w_shift    = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_mosi_nxt = 1'b0;
                    if (r_is_read) begin
                        w_cnt_nxt   = GAP_INIT;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_finish = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = RECV_INIT;
                    w_state_nxt = ST_RECV;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RECV: begin
                w_capture = 1'b1;
                if (r_cnt == '0) begin
                    w_rsp_data_nxt  = w_rx_next;
                    w_rsp_valid_nxt = 1'b1;
                    w_finish        = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_cmd_ready_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // The ready cycle in IDLE is the last SS_n-high cycle of the gap, so a
        // held command sees SS_n high for exactly IDLE_GAP cycles.
        if (w_finish) begin
            w_ss_n_nxt = 1'b1;
            if (IDLE_GAP > 1) begin
                w_cnt_nxt   = HOLD_INIT;
                w_state_nxt = ST_HOLD;
            end else begin
                w_cmd_ready_nxt = 1'b1;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign SS_n          = r_ss_n;
    assign MOSI          = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (FRAME_WIDTH=8, RD_GAP=2, IDLE_GAP=1)
// with a scripted MISO reply for read-data frames.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic MISO = 1'b0;
    logic SS_n;
    logic MOSI;

    int tests = 0;
    int fails = 0;
    int waited;

    spi_master_ctrl_if #(.FRAME_WIDTH(8)) bus ();

    spi_master_ctrl #(
        .FRAME_WIDTH (8),
        .RD_GAP      (2),
        .IDLE_GAP    (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one command, waits for accept, then follows it edge by edge.
    // Returns one tick after the frame's last MOSI bit for writes, or one tick
    // after the rsp_valid pulse for read-data.
    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] data,
                        input logic [10:0] exp_frame, input logic [7:0] rx,
                        input bit keep, input bit scramble, output int wcnt);
        logic [10:0] bits;
        bit ss_ok;
        bit rdy_ok;
        bit early;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        wcnt = 0;
        while (bus.cmd_ready !== 1'b1 && wcnt < 40) begin
            tick();
            wcnt++;
        end
        if (wcnt >= 40) begin
            chk($sformatf("%s_accept_timeout", tag), wcnt, 0);
            bus.cmd_valid = 1'b0;
            return;
        end
        tick();
        if (!keep) bus.cmd_valid = 1'b0;
        chk($sformatf("%s_ss_low", tag), SS_n, 1'b0);
        chk($sformatf("%s_ready_low", tag), bus.cmd_ready, 1'b0);
        chk($sformatf("%s_busy", tag), bus.busy, 1'b1);
        chk($sformatf("%s_mosi_setup", tag), MOSI, 1'b0);
        bits   = '0;
        ss_ok  = 1'b1;
        rdy_ok = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            bits   = {bits[9:0], MOSI};
            ss_ok  = ss_ok & (SS_n === 1'b0);
            rdy_ok = rdy_ok & (bus.cmd_ready === 1'b0);
            if (scramble) begin
                bus.cmd_data = 8'($urandom);
                bus.cmd_op   = 2'($urandom);
            end
        end
        chk($sformatf("%s_frame", tag), bits, exp_frame);
        chk($sformatf("%s_ss_during_frame", tag), ss_ok, 1'b1);
        chk($sformatf("%s_ready_during_frame", tag), rdy_ok, 1'b1);
        tick();
        chk($sformatf("%s_mosi_end", tag), MOSI, 1'b0);
        if (op != 2'b11) begin
            chk($sformatf("%s_ss_high", tag), SS_n, 1'b1);
            chk($sformatf("%s_ready_high", tag), bus.cmd_ready, 1'b1);
            chk($sformatf("%s_busy_low", tag), bus.busy, 1'b0);
            return;
        end
        chk($sformatf("%s_ss_gap", tag), SS_n, 1'b0);
        chk($sformatf("%s_rsp_idle", tag), bus.rsp_valid, 1'b0);
        MISO = ~rx[7];
        tick();
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            MISO = rx[7-i];
            tick();
            if (i < 7) early = early | (bus.rsp_valid === 1'b1);
        end
        chk($sformatf("%s_rsp_early", tag), early, 1'b0);
        chk($sformatf("%s_rsp_valid", tag), bus.rsp_valid, 1'b1);
        chk($sformatf("%s_rsp_data", tag), bus.rsp_data, rx);
        chk($sformatf("%s_ss_high", tag), SS_n, 1'b1);
        chk($sformatf("%s_ready_high", tag), bus.cmd_ready, 1'b1);
        MISO = ~MISO;
        tick();
        chk($sformatf("%s_rsp_pulse", tag), bus.rsp_valid, 1'b0);
        chk($sformatf("%s_rsp_hold", tag), bus.rsp_data, rx);
        MISO = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ss", SS_n, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        rst = 1'b0;
        tick();

        // Single write-address frame.
        send("wr_addr", 2'b00, 8'hA5, 11'b000_10100101, 8'h00, 1'b0, 1'b0, waited);
        chk("wr_addr_wait", waited, 0);
        tick();
        tick();

        // Back-to-back: second frame must start on the first ready cycle.
        send("wr_data", 2'b01, 8'h3C, 11'b001_00111100, 8'h00, 1'b1, 1'b0, waited);
        send("rd_addr", 2'b10, 8'hA5, 11'b110_10100101, 8'h00, 1'b0, 1'b0, waited);
        chk("b2b_gap_wait", waited, 0);
        tick();

        // Read-data frames with scripted replies.
        send("rd_data", 2'b11, 8'h00, 11'b111_00000000, 8'h3C, 1'b0, 1'b0, waited);
        tick();
        send("rd_data2", 2'b11, 8'h5A, 11'b111_01011010, 8'h81, 1'b0, 1'b0, waited);
        tick();

        // Source keeps cmd_valid high and scrambles payload during the frame.
        send("stall", 2'b00, 8'hC3, 11'b000_11000011, 8'h00, 1'b1, 1'b1, waited);
        send("after_stall", 2'b01, 8'h0F, 11'b001_00001111, 8'h00, 1'b0, 1'b0, waited);
        chk("after_stall_wait", waited, 0);
        tick();

        // Reset in the middle of a read-data capture.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_data  = 8'hFF;
        tick();
        bus.cmd_valid = 1'b0;
        MISO = 1'b1;
        repeat (16) tick();
        chk("mid_recv_ss", SS_n, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_ss", SS_n, 1'b1);
        chk("midrst_mosi", MOSI, 1'b0);
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_rsp_data", bus.rsp_data, 8'h00);
        chk("midrst_ready", bus.cmd_ready, 1'b1);
        chk("midrst_busy", bus.busy, 1'b0);
        tick();
        rst = 1'b0;
        MISO = 1'b0;
        tick();
        chk("postrst_ss", SS_n, 1'b1);
        chk("postrst_rsp_valid", bus.rsp_valid, 1'b0);

        // Reset wins over a simultaneous accept.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h11;
        rst = 1'b1;
        tick();
        chk("rst_prio_ss", SS_n, 1'b1);
        chk("rst_prio_ready", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_prio_idle_ss", SS_n, 1'b1);

        // Fresh read after reset assembles a full new byte.
        send("rd_after_rst", 2'b11, 8'h00, 11'b111_00000000, 8'hE7, 1'b0, 1'b0, waited);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
